// File: rtl/video_timing_decoder.sv
// Recovers x/y, measures raster geometry and declares lock from an hs/vs/de stream in the pixel clock domain.
// All outputs registered one cycle after the sampled inputs; pure receiver, no backpressure path.
module video_timing_decoder #(
    parameter int HOR_TOTAL_PIXELS  = 1650,
    parameter int HOR_ACTIVE_PIXELS = 1280,
    parameter int VER_TOTAL_PIXELS  = 750,
    parameter int VER_ACTIVE_PIXELS = 720,
    parameter int SYNC_ACTIVE_HIGH  = 1,
    parameter int LOCK_FRAMES       = 2,
    parameter int MEAS_WIDTH        = 16,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                  clk_rgb,
    input  logic                  rst,
    input  logic                  hs,
    input  logic                  vs,
    input  logic                  de,
    output logic [X_WIDTH-1:0]    x,
    output logic [Y_WIDTH-1:0]    y,
    output logic                  pixel_valid,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  locked,
    output logic                  timing_err,
    output logic [MEAS_WIDTH-1:0] meas_hor_total,
    output logic [MEAS_WIDTH-1:0] meas_hor_active,
    output logic [MEAS_WIDTH-1:0] meas_ver_total,
    output logic [MEAS_WIDTH-1:0] meas_ver_active
);
    localparam logic                  SYNC_POL = (SYNC_ACTIVE_HIGH != 0);
    localparam int                    GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [MEAS_WIDTH-1:0] L_HT     = MEAS_WIDTH'(HOR_TOTAL_PIXELS);
    localparam logic [MEAS_WIDTH-1:0] L_HA     = MEAS_WIDTH'(HOR_ACTIVE_PIXELS);
    localparam logic [MEAS_WIDTH-1:0] L_VT     = MEAS_WIDTH'(VER_TOTAL_PIXELS);
    localparam logic [MEAS_WIDTH-1:0] L_VA     = MEAS_WIDTH'(VER_ACTIVE_PIXELS);
    localparam logic [MEAS_WIDTH-1:0] L_WD     = MEAS_WIDTH'(2 * HOR_TOTAL_PIXELS);

    typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;

    function automatic logic [MEAS_WIDTH-1:0] sat_inc(input logic [MEAS_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t                r_state;
    logic [GW-1:0]         r_good;
    logic                  r_hs_q, r_vs_q, r_de_q;
    logic                  r_hs_seen, r_vs_seen, r_wd_armed, r_y_restart, r_line_bad;
    logic [MEAS_WIDTH-1:0] r_hcnt, r_dcnt, r_vlines, r_vact;

    logic w_hs, w_vs, w_hs_edge, w_vs_edge, w_de_rise, w_de_fall;
    logic w_hline_bad, w_drun_bad, w_frame_bad, w_eval, w_wd_fire;

    assign w_hs        = (hs == SYNC_POL);
    assign w_vs        = (vs == SYNC_POL);
    assign w_hs_edge   = w_hs & ~r_hs_q;
    assign w_vs_edge   = w_vs & ~r_vs_q;
    assign w_de_rise   = de & ~r_de_q;
    assign w_de_fall   = ~de & r_de_q;
    assign w_hline_bad = w_hs_edge & r_hs_seen & (r_hcnt != L_HT);
    assign w_drun_bad  = w_de_fall & (r_dcnt != L_HA);
    // This cycle's line checks still belong to the frame being closed by a coincident vs edge.
    assign w_frame_bad = r_line_bad | w_hline_bad | w_drun_bad | (r_vlines != L_VT) | (r_vact != L_VA);
    assign w_eval      = w_vs_edge & r_vs_seen;
    assign w_wd_fire   = r_wd_armed & ~w_hs_edge & (r_hcnt >= L_WD);

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            r_state         <= S_UNLOCKED;
            r_good          <= '0;
            r_hs_q          <= 1'b0;
            r_vs_q          <= 1'b0;
            r_de_q          <= 1'b0;
            r_hs_seen       <= 1'b0;
            r_vs_seen       <= 1'b0;
            r_wd_armed      <= 1'b0;
            r_y_restart     <= 1'b0;
            r_line_bad      <= 1'b0;
            r_hcnt          <= '0;
            r_dcnt          <= '0;
            r_vlines        <= '0;
            r_vact          <= '0;
            x               <= '0;
            y               <= '0;
            pixel_valid     <= 1'b0;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            locked          <= 1'b0;
            timing_err      <= 1'b0;
            meas_hor_total  <= '0;
            meas_hor_active <= '0;
            meas_ver_total  <= '0;
            meas_ver_active <= '0;
        end else begin
            r_hs_q      <= w_hs;
            r_vs_q      <= w_vs;
            r_de_q      <= de;
            pixel_valid <= de;
            line_start  <= w_hs_edge;
            frame_start <= w_vs_edge;
            timing_err  <= 1'b0;

            if (de) begin
                if (w_de_rise)    x <= '0;
                else if (x != '1) x <= x + 1'b1;
            end
            if (w_de_rise) begin
                if (r_y_restart | w_vs_edge) y <= '0;
                else if (y != '1)            y <= y + 1'b1;
            end
            if (w_de_rise)      r_y_restart <= 1'b0;
            else if (w_vs_edge) r_y_restart <= 1'b1;

            if (w_hs_edge) begin
                r_hcnt     <= MEAS_WIDTH'(1);
                r_hs_seen  <= 1'b1;
                r_wd_armed <= 1'b1;
                if (r_hs_seen) meas_hor_total <= r_hcnt;
            end else begin
                r_hcnt <= sat_inc(r_hcnt);
            end
            if (de)        r_dcnt          <= w_de_rise ? MEAS_WIDTH'(1) : sat_inc(r_dcnt);
            if (w_de_fall) meas_hor_active <= r_dcnt;

            if (w_vs_edge) begin
                r_vlines   <= w_hs_edge ? MEAS_WIDTH'(1) : '0;
                r_vact     <= w_de_rise ? MEAS_WIDTH'(1) : '0;
                r_line_bad <= 1'b0;
                r_vs_seen  <= 1'b1;
                if (r_vs_seen) begin
                    meas_ver_total  <= r_vlines;
                    meas_ver_active <= r_vact;
                end
            end else begin
                if (w_hs_edge)                r_vlines   <= sat_inc(r_vlines);
                if (w_de_rise)                r_vact     <= sat_inc(r_vact);
                if (w_hline_bad | w_drun_bad) r_line_bad <= 1'b1;
            end

            // Watchdog wins over frame evaluation and forces a fresh acquisition.
            if (w_wd_fire) begin
                r_state    <= S_UNLOCKED;
                r_good     <= '0;
                locked     <= 1'b0;
                timing_err <= 1'b1;
                r_wd_armed <= 1'b0;
                r_hs_seen  <= 1'b0;
                r_vs_seen  <= 1'b0;
            end else if (w_eval) begin
                if (w_frame_bad) begin
                    r_state    <= S_UNLOCKED;
                    r_good     <= '0;
                    locked     <= 1'b0;
                    timing_err <= 1'b1;
                end else if (r_state == S_LOCKED) begin
                    locked <= 1'b1;
                end else if (r_good == GW'(LOCK_FRAMES - 1)) begin
                    r_state <= S_LOCKED;
                    r_good  <= GW'(LOCK_FRAMES);
                    locked  <= 1'b1;
                end else begin
                    r_good <= r_good + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench: 16/8/10/6 raster, one active-high and one active-low decoder fed the same stream.
module tb_video_timing_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic hs_n, vs_n;
    assign hs_n = ~hs;
    assign vs_n = ~vs;

    logic [2:0]  x_a, y_a, x_b, y_b;
    logic        pv_a, ls_a, fs_a, lk_a, te_a, pv_b, ls_b, fs_b, lk_b, te_b;
    logic [15:0] mht_a, mha_a, mvt_a, mva_a, mht_b, mha_b, mvt_b, mva_b;

    video_timing_decoder #(.HOR_TOTAL_PIXELS(16), .HOR_ACTIVE_PIXELS(8), .VER_TOTAL_PIXELS(10),
        .VER_ACTIVE_PIXELS(6), .SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(2), .MEAS_WIDTH(16)) dut_a (
        .clk_rgb(clk), .rst(rst), .hs(hs), .vs(vs), .de(de), .x(x_a), .y(y_a),
        .pixel_valid(pv_a), .line_start(ls_a), .frame_start(fs_a), .locked(lk_a), .timing_err(te_a),
        .meas_hor_total(mht_a), .meas_hor_active(mha_a), .meas_ver_total(mvt_a), .meas_ver_active(mva_a));

    video_timing_decoder #(.HOR_TOTAL_PIXELS(16), .HOR_ACTIVE_PIXELS(8), .VER_TOTAL_PIXELS(10),
        .VER_ACTIVE_PIXELS(6), .SYNC_ACTIVE_HIGH(0), .LOCK_FRAMES(2), .MEAS_WIDTH(16)) dut_b (
        .clk_rgb(clk), .rst(rst), .hs(hs_n), .vs(vs_n), .de(de), .x(x_b), .y(y_b),
        .pixel_valid(pv_b), .line_start(ls_b), .frame_start(fs_b), .locked(lk_b), .timing_err(te_b),
        .meas_hor_total(mht_b), .meas_hor_active(mha_b), .meas_ver_total(mvt_b), .meas_ver_active(mva_b));

    int checks = 0;
    int errors = 0;

    // Values captured on the first cycle of a frame (just after its vs edge) and over the whole frame.
    logic        fs_lk_a, fs_te_a, fs_fs_a, fs_lk_b, lc_lk_a;
    logic [15:0] fs_mht_a, fs_mha_a, fs_mvt_a, fs_mva_a, fs_mht_b, fs_mha_b, fs_mvt_b, fs_mva_b, lc_mht_a;
    logic [2:0]  lc_x_b, lc_y_b;
    int          n_te_a, n_pv_a, n_ls_a, n_te_b, n_pv_b;

    task automatic step(input logic h_s, input logic v_s, input logic d);
        hs = h_s;
        vs = v_s;
        de = d;
        @(posedge clk);
        #1;
    endtask

    // Raster: hs on h 0..1, vs on lines 0..1, de on h 4..11 of lines 2..7.
    task automatic drive_px(input int h, input int v);
        step(h < 2, v < 2, (h >= 4) && (h < 12) && (v >= 2) && (v < 8));
    endtask

    task automatic run_frame(input int long_v);
        n_te_a = 0; n_pv_a = 0; n_ls_a = 0; n_te_b = 0; n_pv_b = 0;
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < ((v == long_v) ? 17 : 16); h++) begin
                drive_px(h, v);
                if (v == 0 && h == 0) begin
                    fs_lk_a = lk_a; fs_te_a = te_a; fs_fs_a = fs_a; fs_lk_b = lk_b;
                    fs_mht_a = mht_a; fs_mha_a = mha_a; fs_mvt_a = mvt_a; fs_mva_a = mva_a;
                    fs_mht_b = mht_b; fs_mha_b = mha_b; fs_mvt_b = mvt_b; fs_mva_b = mva_b;
                end
                n_te_a += int'(te_a); n_pv_a += int'(pv_a); n_ls_a += int'(ls_a);
                n_te_b += int'(te_b); n_pv_b += int'(pv_b);
            end
        end
        lc_lk_a = lk_a; lc_mht_a = mht_a; lc_x_b = x_b; lc_y_b = y_b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({x_a, y_a, pv_a, ls_a, fs_a, lk_a, te_a, mht_a, mha_a, mvt_a, mva_a} !== '0) begin
            errors++; $display("FAIL reset_a got %h want 0", {x_a, y_a, pv_a, ls_a, fs_a, lk_a, te_a, mht_a, mha_a, mvt_a, mva_a});
        end
        checks++;
        if ({x_b, y_b, pv_b, ls_b, fs_b, lk_b, te_b, mht_b, mha_b, mvt_b, mva_b} !== '0) begin
            errors++; $display("FAIL reset_b got %h want 0", {x_b, y_b, pv_b, ls_b, fs_b, lk_b, te_b, mht_b, mha_b, mvt_b, mva_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_lock_acquire();
        run_frame(-1);
        checks++; if (fs_fs_a !== 1'b1) begin errors++; $display("FAIL acq_frame_start got %0d want 1", fs_fs_a); end
        checks++; if (fs_lk_a !== 1'b0 || fs_te_a !== 1'b0) begin errors++; $display("FAIL acq_vs1 lk/te got %0d/%0d want 0/0", fs_lk_a, fs_te_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0) begin errors++; $display("FAIL acq_vs2_locked got %0d want 0", fs_lk_a); end
        checks++; if (lc_lk_a !== 1'b0) begin errors++; $display("FAIL acq_pre_vs3_locked got %0d want 0", lc_lk_a); end
        checks++; if (n_pv_a != 48) begin errors++; $display("FAIL acq_valid_count got %0d want 48", n_pv_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b1) begin errors++; $display("FAIL acq_vs3_locked got %0d want 1", fs_lk_a); end
        checks++;
        if ({fs_mht_a, fs_mha_a, fs_mvt_a, fs_mva_a} !== {16'd16, 16'd8, 16'd10, 16'd6}) begin
            errors++; $display("FAIL acq_meas got %0d/%0d/%0d/%0d want 16/8/10/6", fs_mht_a, fs_mha_a, fs_mvt_a, fs_mva_a);
        end
        checks++; if (n_te_a != 0) begin errors++; $display("FAIL acq_no_err got %0d want 0", n_te_a); end
    endtask

    task automatic test_pixels();
        int nvalid = 0;
        int nls = 0;
        int bad = 0;
        logic [2:0] ex_y;
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 16; h++) begin
                drive_px(h, v);
                nls += int'(ls_a);
                if ((h >= 4) && (h < 12) && (v >= 2) && (v < 8)) begin
                    nvalid++;
                    checks++;
                    if ({pv_a, x_a, y_a} !== {1'b1, 3'(h - 4), 3'(v - 2)}) begin
                        errors++; bad++;
                        if (bad < 5) $display("FAIL pix h%0d v%0d got pv%0d x%0d y%0d want pv1 x%0d y%0d", h, v, pv_a, x_a, y_a, h - 4, v - 2);
                    end
                end else begin
                    if ((v >= 2) && (v < 8)) ex_y = (h >= 12) ? 3'(v - 2) : ((v == 2) ? 3'd5 : 3'(v - 3));
                    else                     ex_y = 3'd5;
                    checks++;
                    if ({pv_a, x_a, y_a} !== {1'b0, 3'd7, ex_y}) begin
                        errors++; bad++;
                        if (bad < 5) $display("FAIL hold h%0d v%0d got pv%0d x%0d y%0d want pv0 x7 y%0d", h, v, pv_a, x_a, y_a, ex_y);
                    end
                end
            end
        end
        checks++; if (nvalid != 48) begin errors++; $display("FAIL pix_count got %0d want 48", nvalid); end
        checks++; if (nls != 10) begin errors++; $display("FAIL line_start_count got %0d want 10", nls); end
        checks++; if (lk_a !== 1'b1) begin errors++; $display("FAIL pix_locked got %0d want 1", lk_a); end
    endtask

    task automatic test_long_line();
        run_frame(9);
        checks++; if (fs_lk_a !== 1'b1) begin errors++; $display("FAIL long_pre_locked got %0d want 1", fs_lk_a); end
        run_frame(-1);
        checks++; if (fs_te_a !== 1'b1) begin errors++; $display("FAIL long_err got %0d want 1", fs_te_a); end
        checks++; if (fs_lk_a !== 1'b0) begin errors++; $display("FAIL long_unlock got %0d want 0", fs_lk_a); end
        checks++; if (fs_mht_a !== 16'd17) begin errors++; $display("FAIL long_meas_ht got %0d want 17", fs_mht_a); end
        checks++; if (n_te_a != 1) begin errors++; $display("FAIL long_err_count got %0d want 1", n_te_a); end
        checks++; if (lc_mht_a !== 16'd16) begin errors++; $display("FAIL long_meas_ht_back got %0d want 16", lc_mht_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0 || fs_te_a !== 1'b0) begin errors++; $display("FAIL relock1 lk/te got %0d/%0d want 0/0", fs_lk_a, fs_te_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b1) begin errors++; $display("FAIL relock2 got %0d want 1", fs_lk_a); end
    endtask

    task automatic test_watchdog();
        int first = -1;
        int npulse = 0;
        logic lk_before = 1'b0;
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < ((v == 3) ? 4 : 16); h++) drive_px(h, v);
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i == 28) lk_before = lk_a;
            if (te_a === 1'b1) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        checks++; if (first != 29) begin errors++; $display("FAIL wd_pulse_cycle got %0d want 29", first); end
        checks++; if (npulse != 1) begin errors++; $display("FAIL wd_pulse_count got %0d want 1", npulse); end
        checks++; if (lk_before !== 1'b1) begin errors++; $display("FAIL wd_locked_before got %0d want 1", lk_before); end
        checks++; if (lk_a !== 1'b0) begin errors++; $display("FAIL wd_unlocked got %0d want 0", lk_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0 || n_te_a != 0) begin errors++; $display("FAIL wd_resume1 lk/err got %0d/%0d want 0/0", fs_lk_a, n_te_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0) begin errors++; $display("FAIL wd_resume2 got %0d want 0", fs_lk_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b1) begin errors++; $display("FAIL wd_resume3 got %0d want 1", fs_lk_a); end
    endtask

    task automatic test_reset_mid();
        int nerr = 0;
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 16; h++) drive_px(h, v);
        for (int h = 0; h < 6; h++) drive_px(h, 4);
        rst = 1'b1;
        drive_px(6, 4);
        rst = 1'b0;
        checks++;
        if ({x_a, y_a, pv_a, ls_a, fs_a, lk_a, te_a, mht_a, mha_a, mvt_a, mva_a} !== '0) begin
            errors++; $display("FAIL midrst_a got %h want 0", {x_a, y_a, pv_a, ls_a, fs_a, lk_a, te_a, mht_a, mha_a, mvt_a, mva_a});
        end
        checks++;
        if ({x_b, y_b, pv_b, ls_b, fs_b, lk_b, te_b, mht_b, mha_b, mvt_b, mva_b} !== '0) begin
            errors++; $display("FAIL midrst_b got %h want 0", {x_b, y_b, pv_b, ls_b, fs_b, lk_b, te_b, mht_b, mha_b, mvt_b, mva_b});
        end
        for (int v = 4; v < 10; v++)
            for (int h = ((v == 4) ? 7 : 0); h < 16; h++) begin
                drive_px(h, v);
                nerr += int'(te_a);
            end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0 || fs_te_a !== 1'b0 || nerr != 0) begin errors++; $display("FAIL midrst_vs1 lk/te/err got %0d/%0d/%0d want 0/0/0", fs_lk_a, fs_te_a, nerr); end
        checks++; if (fs_mvt_a !== 16'd0) begin errors++; $display("FAIL midrst_partial_discard got %0d want 0", fs_mvt_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b0) begin errors++; $display("FAIL midrst_vs2 got %0d want 0", fs_lk_a); end
        run_frame(-1);
        checks++; if (fs_lk_a !== 1'b1) begin errors++; $display("FAIL midrst_vs3 got %0d want 1", fs_lk_a); end
    endtask

    task automatic test_active_low();
        int nerr = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run_frame(-1);
        nerr += n_te_b;
        checks++; if (fs_lk_b !== 1'b0) begin errors++; $display("FAIL low_vs1 got %0d want 0", fs_lk_b); end
        run_frame(-1);
        nerr += n_te_b;
        checks++; if (fs_lk_b !== 1'b0) begin errors++; $display("FAIL low_vs2 got %0d want 0", fs_lk_b); end
        checks++; if (n_pv_b != 48) begin errors++; $display("FAIL low_valid_count got %0d want 48", n_pv_b); end
        run_frame(-1);
        nerr += n_te_b;
        checks++; if (fs_lk_b !== 1'b1) begin errors++; $display("FAIL low_vs3 got %0d want 1", fs_lk_b); end
        checks++;
        if ({fs_mht_b, fs_mha_b, fs_mvt_b, fs_mva_b} !== {16'd16, 16'd8, 16'd10, 16'd6}) begin
            errors++; $display("FAIL low_meas got %0d/%0d/%0d/%0d want 16/8/10/6", fs_mht_b, fs_mha_b, fs_mvt_b, fs_mva_b);
        end
        checks++; if ({lc_x_b, lc_y_b} !== {3'd7, 3'd5}) begin errors++; $display("FAIL low_xy_end got x%0d y%0d want x7 y5", lc_x_b, lc_y_b); end
        checks++; if (nerr != 0) begin errors++; $display("FAIL low_no_err got %0d want 0", nerr); end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_pixels();
        test_long_line();
        test_watchdog();
        test_reset_mid();
        test_active_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
